// File: rtl/bus_if_pkg.sv
// Shared types and constants for the bus_if memory bus block.
// Optional auto-increment addressing is enabled with BUS_IF_AUTOINC_EN.
package bus_if_pkg;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 8;

    // Values the observable bus registers take while rst_n is low.
    localparam int   BUS_ADDR_RST = 0;
    localparam int   BUS_DATA_RST = 0;
    localparam logic BUS_RWN_RST  = 1'b1;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

endpackage

// File: rtl/bus_if_ram.sv
// Single-port synchronous RAM for bus_if.
// It has one write port and a registered read port.
module bus_if_ram
    import bus_if_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // NOTE: storage arrays take no reset, so they can map onto RAM macros; contents survive rst_n.
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        if (re) rdata <= mem[addr];
    end

endmodule

// File: rtl/bus_if.sv
// Registered single-master bus front end with its local RAM target.
// Define BUS_IF_AUTOINC_EN to add req_inc, which selects the address bus_addr+1.
module bus_if
    import bus_if_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_rwn,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
`ifdef BUS_IF_AUTOINC_EN
    input  logic              req_inc,
`endif
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_data,
    output logic              bus_rwn
);

    state_t            state, state_nxt;
    logic              accept, ram_we, ram_re;
    logic [ADDR_W-1:0] addr_nxt;
    logic [DATA_W-1:0] data_q, rsp_q, ram_rdata;
    // When a read completes, bus_data and rsp_rdata come straight from the RAM read register.
    logic              bus_sel_ram, rsp_sel_ram;

`ifdef BUS_IF_AUTOINC_EN
    assign addr_nxt = req_inc ? bus_addr + ADDR_W'(1) : req_addr;
`else
    assign addr_nxt = req_addr;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // NOTE: every output of this block is given a default first, so no path can leave one unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        accept    = 1'b0;
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                accept    = req_valid;
                if (req_valid) state_nxt = ACCESS;
            end
            ACCESS: begin
                ram_we    = !bus_rwn;
                ram_re    = bus_rwn;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_addr    <= ADDR_W'(BUS_ADDR_RST);
            data_q      <= DATA_W'(BUS_DATA_RST);
            bus_rwn     <= BUS_RWN_RST;
            rsp_valid   <= 1'b0;
            rsp_q       <= '0;
            bus_sel_ram <= 1'b0;
            rsp_sel_ram <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            if (accept) begin
                bus_addr <= addr_nxt;
                bus_rwn  <= req_rwn;
                if (!req_rwn) begin
                    data_q      <= req_wdata;
                    bus_sel_ram <= 1'b0;
                end
            end
            if (state == ACCESS) begin
                rsp_valid <= 1'b1;
                if (bus_rwn) begin
                    bus_sel_ram <= 1'b1;
                    rsp_sel_ram <= 1'b1;
                end else begin
                    rsp_q       <= data_q;
                    rsp_sel_ram <= 1'b0;
                end
            end
        end
    end

    assign bus_data  = bus_sel_ram ? ram_rdata : data_q;
    assign rsp_rdata = rsp_sel_ram ? ram_rdata : rsp_q;

    bus_if_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (bus_addr),
        .wdata (data_q),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_bus_if.sv
// Scoreboard testbench for bus_if. A byte-array reference model predicts each response.
// The directed auto-increment tests run only when BUS_IF_AUTOINC_EN is defined.
module tb_bus_if;

    typedef struct {
        logic [7:0] addr;
        logic       rwn;
        logic [7:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_rwn = 1'b1;
    logic [7:0] req_addr = '0;
    logic [7:0] req_wdata = '0;
    logic       req_inc = 1'b0;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic [7:0] bus_addr;
    logic [7:0] bus_data;
    logic       bus_rwn;

    int         n_pass = 0;
    int         n_total = 0;
    int         n_issued = 0;
    int         n_rsp = 0;
    exp_t       exp_q[$];
    logic [7:0] mem_model [256];
    bit         written [256];
    logic [7:0] model_bus_addr = 8'h00;

    bus_if #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_rwn   (req_rwn),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
`ifdef BUS_IF_AUTOINC_EN
        .req_inc   (req_inc),
`endif
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .bus_addr  (bus_addr),
        .bus_data  (bus_data),
        .bus_rwn   (bus_rwn)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Monitor: every response strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && rsp_valid) begin
            n_rsp++;
            if (exp_q.size() == 0) begin
                check("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("rsp_rdata", {24'd0, rsp_rdata}, {24'd0, e.data});
                check("bus_data",  {24'd0, bus_data},  {24'd0, e.data});
                check("bus_addr",  {24'd0, bus_addr},  {24'd0, e.addr});
                check("bus_rwn",   {31'd0, bus_rwn},   {31'd0, e.rwn});
            end
        end
    end

    // Drives one request and waits for it to be accepted.
    // This is called just after a rising edge and returns just after the acceptance edge.
    task automatic issue(input logic rwn, input logic [7:0] addr, input logic [7:0] wdata,
                         input logic inc, input bit expect_rsp, output int waited);
        logic [7:0] eff;
        exp_t       e;
        req_valid = 1'b1;
        req_rwn   = rwn;
        req_addr  = addr;
        req_wdata = wdata;
        req_inc   = inc;
        waited    = 0;
        forever begin
            @(negedge clk);
            if (req_ready) break;
            waited++;
            if (waited > 20) begin
                check("accept_timeout", 32'd1, 32'd0);
                @(posedge clk); #1;
                return;
            end
        end
        @(posedge clk); #1;
        eff = inc ? model_bus_addr + 8'd1 : addr;
        model_bus_addr = eff;
        if (!expect_rsp) return;
        n_issued++;
        e.addr = eff;
        e.rwn  = rwn;
        if (rwn) begin
            e.data = mem_model[eff];
        end else begin
            e.data = wdata;
            mem_model[eff] = wdata;
            written[eff]   = 1'b1;
        end
        exp_q.push_back(e);
    endtask

    task automatic idle(input int cycles);
        req_valid = 1'b0;
        req_inc   = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    initial begin
        int         w;
        logic       rwn, inc;
        logic [7:0] addr, eff;

        #12;
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_rdata", {24'd0, rsp_rdata}, 32'd0);
        check("rst_bus_addr",  {24'd0, bus_addr},  32'd0);
        check("rst_bus_data",  {24'd0, bus_data},  32'd0);
        check("rst_bus_rwn",   {31'd0, bus_rwn},   32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Write then read back.
        issue(1'b0, 8'h10, 8'hA5, 1'b0, 1'b1, w);
        idle(2);
        issue(1'b1, 8'h10, 8'h00, 1'b0, 1'b1, w);
        idle(3);
        issue(1'b0, 8'h20, 8'h11, 1'b0, 1'b1, w);

        // Back-to-back: the second request is held through ACCESS and then accepted once.
        issue(1'b0, 8'h30, 8'h5A, 1'b0, 1'b1, w);
        check("busy_ready_low", {31'd0, req_ready}, 32'd0);
        issue(1'b1, 8'h30, 8'h00, 1'b0, 1'b1, w);
        check("backpressure_wait", w, 32'd1);
        idle(3);

`ifdef BUS_IF_AUTOINC_EN
        issue(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, w);
        for (int i = 1; i < 8; i++) begin
            issue(1'b0, 8'hEE, 8'(8'h40 + i), 1'b1, 1'b1, w);
            check("autoinc_bus_addr", {24'd0, bus_addr}, i);
        end
        issue(1'b1, 8'h07, 8'h00, 1'b0, 1'b1, w);
        issue(1'b0, 8'hFF, 8'hC3, 1'b0, 1'b1, w);
        issue(1'b1, 8'h55, 8'h00, 1'b1, 1'b1, w);
        check("wrap_bus_addr", {24'd0, bus_addr}, 32'd0);
        idle(3);
`endif

        // Reset during ACCESS: the write to 0x20 must be abandoned.
        issue(1'b0, 8'h20, 8'h3C, 1'b0, 1'b0, w);
        rst_n = 1'b0;
        req_valid = 1'b0;
        #1;
        check("midrst_req_ready", {31'd0, req_ready}, 32'd1);
        check("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("midrst_bus_addr",  {24'd0, bus_addr},  32'd0);
        check("midrst_bus_data",  {24'd0, bus_data},  32'd0);
        check("midrst_bus_rwn",   {31'd0, bus_rwn},   32'd1);
        check("midrst_rsp_rdata", {24'd0, rsp_rdata}, 32'd0);
        model_bus_addr = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        issue(1'b1, 8'h20, 8'h00, 1'b0, 1'b1, w);
        idle(3);

        // Random traffic. A read aimed at a location never written becomes a write.
        for (int n = 0; n < 200; n++) begin
            rwn  = 1'($urandom_range(0, 1));
            addr = 8'($urandom_range(0, 255));
`ifdef BUS_IF_AUTOINC_EN
            inc = ($urandom_range(0, 3) == 0);
`else
            inc = 1'b0;
`endif
            eff = inc ? model_bus_addr + 8'd1 : addr;
            if (rwn && !written[eff]) rwn = 1'b0;
            issue(rwn, addr, 8'($urandom_range(0, 255)), inc, 1'b1, w);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
        end

        idle(1);
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        check("drain", exp_q.size(), 32'd0);
        check("rsp_count", n_rsp, n_issued);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/bus_if.md
# bus_if

Registered single-master memory bus with an attached 256×8 RAM target. A requester issues read/write transactions over a valid/ready handshake. The block drives the shared address, data and read/write-not signals, which are also exposed for observation, and performs the access on its internal RAM. It returns read data, or echoes write data, on a one-cycle response strobe. It sits between a test or control master and local byte storage.

## Interface
- `ADDR_W`, default 8: address width; RAM depth is 2**ADDR_W.
- `DATA_W`, default 8: data width.

- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `req_valid` input 1: request present.
- `req_ready` output 1: request accepted when `req_valid & req_ready`.
- `req_rwn` input 1: 1 = read, 0 = write.
- `req_addr` input ADDR_W: target address.
- `req_wdata` input DATA_W: write data; ignored for reads.
- `req_inc` input 1: present only with `BUS_IF_AUTOINC_EN`; use the incremented address.
- `rsp_valid` output 1: one-cycle completion strobe.
- `rsp_rdata` output DATA_W: read data, or written data for writes.
- `bus_addr` output ADDR_W: registered bus address.
- `bus_data` output DATA_W: registered bus data.
- `bus_rwn` output 1: registered bus direction.

## Operation
- Two-state FSM:
  - IDLE: `req_ready`=1. On acceptance, load `bus_addr`, `bus_rwn`, and `bus_data` (write data for writes; unchanged for reads), then go to ACCESS.
  - ACCESS: `req_ready`=0. On the next edge, a write stores `mem[bus_addr] <= bus_data`. A read loads `bus_data` and `rsp_rdata` with `mem[bus_addr]`. In both cases `rsp_valid` is set for one cycle and the FSM returns to IDLE.
- For writes, `rsp_rdata` = written data.
- `bus_*` hold their values between transactions.
- Unsigned arithmetic; address increment wraps modulo 2**ADDR_W (255→0 at default width).
- RAM contents are not reset and are undefined until written. Reads of unwritten locations return X in simulation.
- A request held while `req_ready`=0 is not lost. The requester keeps `req_valid` and its fields stable until acceptance.

## Timing
- Acceptance edge = T. ACCESS completes at T+1. `rsp_valid`=1 during the cycle after T+1.
- Back-to-back throughput: one transaction per 2 cycles. A new request may be accepted in the same cycle `rsp_valid` is high.
- Reset values:
  - `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0
  - `bus_addr`=0, `bus_data`=0, `bus_rwn`=1
  - FSM=IDLE
- Reset asserted mid-ACCESS: the access is abandoned. No RAM write occurs, no response is produced, and all outputs take their reset values immediately (asynchronously). RAM contents are preserved.

## Configuration
- `BUS_IF_AUTOINC_EN` defined:
  - `req_inc` port exists.
  - An accepted request with `req_inc`=1 uses `bus_addr+1` (wrapping) as the address and ignores `req_addr`.
  - With `req_inc`=0, behaviour is unchanged.
- Not defined: no `req_inc` port, and the address is always `req_addr`.

## Structure
- Package `bus_if_pkg`:
  - FSM state enum (`IDLE`, `ACCESS`)
  - default width constants
  - reset-value constants for the `bus_*` outputs
- Sub-module `bus_if_ram`: synchronous 2**ADDR_W × DATA_W array, one write port and one registered read port, no reset.
- `bus_if` holds the FSM, bus registers, increment logic and response registers.

## Test plan
- Reset: assert `rst_n`=0 → `req_ready`=1, `rsp_valid`=0, `bus_addr`=0x00, `bus_data`=0x00, `bus_rwn`=1.
- Write then read back:
  - Write 0xA5 to 0x10 → `rsp_valid` pulse with `rsp_rdata`=0xA5.
  - Read 0x10 → `rsp_rdata`=0xA5 and `bus_data`=0xA5, two cycles after acceptance.
- Backpressure: hold `req_valid` during ACCESS → `req_ready`=0, no second acceptance. The held request is accepted in the next IDLE cycle, and exactly one response follows.
- Auto-increment (`BUS_IF_AUTOINC_EN`):
  - Write 0x00 to addr 0, then seven writes with `req_inc`=1 → `bus_addr` steps 1..7.
  - Then read 7 → its written data.
- Wrap (`BUS_IF_AUTOINC_EN`): access 0xFF, then `req_inc`=1 → `bus_addr`=0x00.
- Reset mid-ACCESS:
  - Write 0x3C to 0x20, then assert `rst_n` during ACCESS → no `rsp_valid`.
  - After release, read 0x20 → its prior value (0x11 written earlier), not 0x3C.
